acc_to_bf16_pipe: RTL and testbench

ACC_TO_BF16_PIPE -- requirements
Module: acc_to_bf16_pipe

---
 rtl/acc_to_bf16_pipe.sv | 134 +++++++++++++
 tb/tb_acc_to_bf16_pipe.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_to_bf16_pipe.sv
// Converts signed fixed-point accumulator lanes to bfloat16 in a two-stage
// valid/ready pipeline. Supports round-to-nearest-even or truncation, selected per beat.
module acc_to_bf16_pipe #(
  parameter int IN_W      = 18,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic                  in_rne,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*16-1:0]   out_data,
  output logic [LANES-1:0]      out_inexact
);

  localparam int LZ_W = $clog2(IN_W + 1);

  function automatic logic [LZ_W-1:0] f_lzc(input logic [IN_W-1:0] v);
    f_lzc = LZ_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) f_lzc = LZ_W'(IN_W - 1 - i);
    end
  endfunction

  // Returns {inexact, bf16}. The shifted magnitude has its leading one at
  // the MSB; two zero pad bits keep the guard/sticky slices legal at IN_W=9.
  function automatic logic [16:0] f_round_pack(input logic sgn,
                                                input logic [IN_W-1:0] mag,
                                                input logic [LZ_W-1:0] lz,
                                                input logic rne);
    logic [IN_W-1:0] sh;
    logic [IN_W:0]   tail;
    logic [6:0]      mant;
    logic [7:0]      mant_inc;
    logic            guard;
    logic            sticky;
    logic            inc;
    int              expo;
    sh       = mag << lz;
    tail     = {sh[IN_W-2:0], 2'b00};
    mant     = tail[IN_W -: 7];
    guard    = tail[IN_W-7];
    sticky   = |tail[IN_W-8:0];
    inc      = rne & guard & (sticky | mant[0]);
    mant_inc = {1'b0, mant} + 8'(inc);
    expo     = 127 + IN_W - 1 - FRAC_BITS - int'(lz);
    if (mant_inc[7]) expo = expo + 1;
    if (!sh[IN_W-1]) f_round_pack = '0;
    else f_round_pack = {guard | sticky, sgn, 8'(expo), mant_inc[6:0]};
  endfunction

  logic                  w_adv_p1;
  logic [LANES-1:0]      w_sgn_p0;
  logic [IN_W-1:0]       w_raw_p0 [LANES];
  logic [IN_W-1:0]       w_mag_p0 [LANES];
  logic [LZ_W-1:0]       w_lz_p0  [LANES];
  logic [LANES*16-1:0]   w_bf_p1;
  logic [LANES-1:0]      w_inx_p1;

  logic                  r_vld_p1;
  logic                  r_rne_p1;
  logic [LANES-1:0]      r_sgn_p1;
  logic [IN_W-1:0]       r_mag_p1 [LANES];
  logic [LZ_W-1:0]       r_lz_p1  [LANES];

  logic                  r_vld_p2;
  logic [LANES*16-1:0]   r_bf_p2;
  logic [LANES-1:0]      r_inx_p2;

  assign w_adv_p1 = !r_vld_p2 | out_ready;
  assign in_ready = !r_vld_p1 | w_adv_p1;

  // Stage 0 -> 1: sign/magnitude split and leading-zero count
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_raw_p0[k] = in_data[k*IN_W +: IN_W];
      w_sgn_p0[k] = w_raw_p0[k][IN_W-1];
      w_mag_p0[k] = w_sgn_p0[k] ? (~w_raw_p0[k] + IN_W'(1)) : w_raw_p0[k];
      w_lz_p0[k]  = f_lzc(w_mag_p0[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_rne_p1 <= in_rne;
      r_sgn_p1 <= w_sgn_p0;
      for (int k = 0; k < LANES; k++) begin
        r_mag_p1[k] <= w_mag_p0[k];
        r_lz_p1[k]  <= w_lz_p0[k];
      end
    end
  end

  // Stage 1 -> 2: normalise, round and pack
  always_comb begin
    w_bf_p1  = '0;
    w_inx_p1 = '0;
    for (int k = 0; k < LANES; k++) begin
      {w_inx_p1[k], w_bf_p1[k*16 +: 16]} =
        f_round_pack(r_sgn_p1[k], r_mag_p1[k], r_lz_p1[k], r_rne_p1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_bf_p2  <= '0;
      r_inx_p2 <= '0;
    end else if (w_adv_p1) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_bf_p2  <= w_bf_p1;
        r_inx_p2 <= w_inx_p1;
      end
    end
  end

  assign out_valid   = r_vld_p2;
  assign out_data    = r_bf_p2;
  assign out_inexact = r_inx_p2;

endmodule

// File: tb/tb_acc_to_bf16_pipe.sv
// Scoreboard bench for acc_to_bf16_pipe: value-level bf16 reference model,
// randomized beats with backpressure, reset-in-flight and a wide-lane instance.
`timescale 1ns/1ps
module tb_acc_to_bf16_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rne, out_valid, out_ready;
  logic [35:0] in_data;
  logic [31:0] out_data;
  logic [1:0]  out_inexact;

  logic        in_valid4, in_ready4, in_rne4, out_valid4, out_ready4;
  logic [95:0] in_data4;
  logic [63:0] out_data4;
  logic [3:0]  out_inexact4;

  always #5 clk = ~clk;

  acc_to_bf16_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rne(in_rne), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_inexact(out_inexact));

  acc_to_bf16_pipe #(.IN_W(24), .FRAC_BITS(0), .LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data4), .in_rne(in_rne4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_inexact(out_inexact4));

  typedef struct {
    logic [31:0] bf;
    logic [1:0]  inx;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   mode = 0;
  bit   lat_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: value-based conversion, {inexact, bf16}
  function automatic logic [16:0] model(input longint v, input int frac, input bit rne);
    longint mag, m, rem, half;
    int     p, sh, e;
    bit     s, inx;
    if (v == 0) return 17'h0;
    s   = (v < 0);
    mag = s ? -v : v;
    p   = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e   = 127 + p - frac;
    inx = 0;
    if (p > 7) begin
      sh   = p - 7;
      m    = mag >> sh;
      rem  = mag - (m << sh);
      inx  = (rem != 0);
      half = longint'(1) << (sh - 1);
      if (rne && ((rem > half) || (rem == half && m[0]))) m = m + 1;
      if (m == 256) begin
        m = 128;
        e = e + 1;
      end
    end else begin
      m = mag << (7 - p);
    end
    return {inx, s, 8'(e), 7'(m & 127)};
  endfunction

  function automatic logic [17:0] rnd_lane();
    logic [17:0] v;
    case ($urandom % 7)
      0: v = 18'h00000;
      1: v = 18'h20000;
      2: v = 18'h1FFFF;
      3: v = 18'($urandom_range(0, 1023));
      4: v = -18'($urandom_range(1, 1023));
      5: v = 18'(($urandom_range(1, 127) << $urandom_range(0, 10)) | 1);
      default: v = 18'($urandom);
    endcase
    return v;
  endfunction

  task automatic send(input logic [35:0] d, input logic rne);
    bit   done;
    exp_t e;
    logic signed [17:0] l;
    logic [16:0] r;
    in_valid = 1'b1;
    in_data  = d;
    in_rne   = rne;
    done     = 0;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        done  = 1;
        e.acc = cyc;
        for (int k = 0; k < 2; k++) begin
          l = d[k*18 +: 18];
          r = model(longint'(l), 8, rne);
          e.bf[k*16 +: 16] = r[15:0];
          e.inx[k] = r[16];
        end
        #1 q.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = {$urandom, 4'($urandom)};
    in_rne   = 1'($urandom);
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_left", 64'(q.size()), 0);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 3) == 0);
        2: out_ready = 1'($urandom);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: in_ready expectation, hold stability, scoreboard pop
  initial begin
    bit          held;
    logic [31:0] held_bf;
    logic [1:0]  held_inx;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
        if (held) begin
          chk("hold_valid", 64'(out_valid), 1);
          chk("hold_data", 64'(out_data), 64'(held_bf));
          chk("hold_inexact", 64'(out_inexact), 64'(held_inx));
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("spurious_out", 0, 1);
            held = 0;
          end else begin
            if (!held) begin
              chk("out_data", 64'(out_data), 64'(q[0].bf));
              chk("out_inexact", 64'(out_inexact), 64'(q[0].inx));
              if (lat_chk) chk("latency", 64'(cyc - q[0].acc), 2);
            end
            if (out_ready) begin
              void'(q.pop_front());
              held = 0;
            end else begin
              held     = 1;
              held_bf  = out_data;
              held_inx = out_inexact;
            end
          end
        end else begin
          held = 0;
        end
      end
    end
  end

  initial begin
    logic [95:0] d4;
    logic signed [23:0] l4;
    logic [16:0] r4;
    int  c0;
    bit  got;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_rne = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; in_rne4 = 1'b0; out_ready4 = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_inexact", 64'(out_inexact), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    lat_chk = 1;
    send({18'h3FF00, 18'h00100}, 1'b0);
    send({18'h1FFFF, 18'h20000}, 1'b1);
    send({18'h1FFFF, 18'h20000}, 1'b0);
    send({18'h00181, 18'h001FF}, 1'b1);
    send({18'h001FF, 18'h00181}, 1'b0);
    send({18'h00000, 18'h00000}, 1'b1);
    send({18'h3FFFF, 18'h00001}, 1'b1);
    drain();
    lat_chk = 0;

    mode = 1;
    for (int i = 0; i < 8; i++) send({rnd_lane(), rnd_lane()}, 1'($urandom));
    drain();

    mode = 2;
    for (int i = 0; i < 300; i++) begin
      send({rnd_lane(), rnd_lane()}, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    mode = 3;
    @(posedge clk);
    #1;
    send({rnd_lane(), rnd_lane()}, 1'b1);
    send({rnd_lane(), rnd_lane()}, 1'b0);
    #2;
    chk("full_out_valid", 64'(out_valid), 1);
    chk("full_in_ready", 64'(in_ready), 0);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 0);
    chk("async_rst_data", 64'(out_data), 0);
    chk("async_rst_inexact", 64'(out_inexact), 0);
    q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mode = 0;
    lat_chk = 1;
    send({18'h1FFFF, 18'h001FF}, 1'b1);
    drain();
    lat_chk = 0;

    d4 = {24'h7FFFFF, 24'h800000, 24'h000000, 24'h000001};
    in_data4 = d4; in_rne4 = 1'b1; in_valid4 = 1'b1;
    @(negedge clk);
    chk("w4_in_ready", 64'(in_ready4), 1);
    c0 = cyc;
    @(posedge clk);
    #1 in_valid4 = 1'b0;
    got = 0;
    for (int t = 0; t < 10 && !got; t++) begin
      @(negedge clk);
      if (out_valid4) got = 1;
    end
    chk("w4_seen", 64'(got), 1);
    if (got) begin
      chk("w4_latency", 64'(cyc - c0), 2);
      for (int k = 0; k < 4; k++) begin
        l4 = d4[k*24 +: 24];
        r4 = model(longint'(l4), 0, 1'b1);
        chk("w4_lane", 64'(out_data4[k*16 +: 16]), 64'(r4[15:0]));
        chk("w4_inexact", 64'(out_inexact4[k]), 64'(r4[16]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
